// File: rtl/hack_vga_pkg.sv
// Shared types and default widths for the Hack screen RAM arbiter.
package hack_vga_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_VGA    = 2'd1,
    GNT_WBUF   = 2'd2,
    GNT_CPU_RD = 2'd3
  } grant_t;
endpackage

// File: rtl/hack_screen_wbuf.sv
// One-entry posted write buffer; a load on the draining edge refills it.
module hack_screen_wbuf
  import hack_vga_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/hack_screen_arbiter.sv
// Screen RAM port arbiter: VGA fixed priority, posted CPU writes, stalled CPU reads.
module hack_screen_arbiter
  import hack_vga_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_rvalid,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);
  grant_t                  grant, gnt_q;
  logic                    wbuf_valid, wr_acc;
  logic [ADDR_WIDTH-1:0]   wbuf_addr;
  logic [DATA_WIDTH-1:0]   wbuf_data;

  // Grant is forced idle while in reset so every output reads zero.
  always_comb begin
    grant = GNT_NONE;
    if (rst_n) begin
      if (vga_req)                grant = GNT_VGA;
      else if (wbuf_valid)        grant = GNT_WBUF;
      else if (cpu_req && !cpu_we) grant = GNT_CPU_RD;
    end
  end

  assign wr_acc    = rst_n & cpu_req & cpu_we & (!wbuf_valid | (grant == GNT_WBUF));
  assign cpu_ready = wr_acc | (grant == GNT_CPU_RD);

  hack_screen_wbuf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wr_acc),
    .drain    (grant == GNT_WBUF),
    .load_addr(cpu_addr),
    .load_data(cpu_wdata),
    .valid    (wbuf_valid),
    .addr     (wbuf_addr),
    .data     (wbuf_data)
  );

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (grant)
      GNT_VGA: begin
        ram_en   = 1'b1;
        ram_addr = vga_addr;
      end
      GNT_WBUF: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = wbuf_addr;
        ram_wdata = wbuf_data;
      end
      GNT_CPU_RD: begin
        ram_en   = 1'b1;
        ram_addr = cpu_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) gnt_q <= GNT_NONE;
    else        gnt_q <= grant;
  end

  // Read data is shared with ram_rdata but held at zero outside its valid cycle.
  assign vga_rvalid = rst_n & (gnt_q == GNT_VGA);
  assign cpu_rvalid = rst_n & (gnt_q == GNT_CPU_RD);
  assign vga_rdata  = vga_rvalid ? ram_rdata : '0;
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (cpu_req && !cpu_ready && (stall_cnt != {CNT_WIDTH{1'b1}}))
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
  end
endmodule
